// File: rtl/univ_reg_cell_if.sv
// Bus for the universal register cell: control and data toward the cell, and
// register state back out of it.
interface univ_reg_cell_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] notq;
  logic             ser_out;
  logic             wrap;

  modport master (
    output en, mode, d, ser_in,
    input  q, notq, ser_out, wrap
  );

  modport slave (
    input  en, mode, d, ser_in,
    output q, notq, ser_out, wrap
  );
endinterface

// File: rtl/univ_reg_cell.sv
// Universal register cell: hold, load, shift, rotate and count on a WIDTH-bit
// register, with serial-out and a one-cycle wrap pulse from counting.
module univ_reg_cell #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic            clk,
  input logic            rst_n,
  univ_reg_cell_if.slave bus
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_UP   = 3'b110,
    MODE_DOWN = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic             ser_q, ser_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] shl_w, shr_w, rol_w, ror_w;
  mode_e            mode_w;

  assign mode_w = mode_e'(bus.mode);

  // A single-bit register has no interior bits to move, so the shifted
  // forms collapse to "take ser_in" and the rotated forms to "keep q".
  generate
    if (WIDTH == 1) begin : g_w1
      assign shl_w = bus.ser_in;
      assign shr_w = bus.ser_in;
      assign rol_w = q_q;
      assign ror_w = q_q;
    end else begin : g_wn
      assign shl_w = {q_q[WIDTH-2:0], bus.ser_in};
      assign shr_w = {bus.ser_in, q_q[WIDTH-1:1]};
      assign rol_w = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      assign ror_w = {q_q[0], q_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    q_d    = q_q;
    ser_d  = ser_q;
    wrap_d = 1'b0;
    if (bus.en) begin
      unique case (mode_w)
        MODE_HOLD: ;
        MODE_LOAD: q_d = bus.d;
        MODE_SHL: begin
          q_d   = shl_w;
          ser_d = q_q[WIDTH-1];
        end
        MODE_SHR: begin
          q_d   = shr_w;
          ser_d = q_q[0];
        end
        MODE_ROL: begin
          q_d   = rol_w;
          ser_d = q_q[WIDTH-1];
        end
        MODE_ROR: begin
          q_d   = ror_w;
          ser_d = q_q[0];
        end
        MODE_UP: begin
          q_d    = q_q + WIDTH'(1);
          wrap_d = &q_q;
        end
        MODE_DOWN: begin
          q_d    = q_q - WIDTH'(1);
          wrap_d = ~|q_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q    <= RESET_VALUE;
      ser_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      ser_q  <= ser_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.notq    = ~q_q;
  assign bus.ser_out = ser_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_univ_reg_cell.sv
// Bench for univ_reg_cell: an 8-bit and a 1-bit cell run side by side against an
// arithmetic reference model, plus directed literal checks.
module tb_univ_reg_cell;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  univ_reg_cell_if #(.WIDTH(8)) bus_a ();
  univ_reg_cell_if #(.WIDTH(1)) bus_b ();

  univ_reg_cell #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut_a (
    .clk(clk), .rst_n(rst_a), .bus(bus_a)
  );
  univ_reg_cell #(.WIDTH(1), .RESET_VALUE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_b), .bus(bus_b)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference: register treated as an unsigned integer in [0, 2^w).
  task automatic model_step(input int w, input int rv, input bit rst, input bit en,
                            input int mode, input int d, input int s,
                            inout int q, inout int so, inout int wr);
    int m;
    m = 1 << w;
    if (!rst) begin
      q = rv; so = 0; wr = 0;
    end else begin
      wr = 0;
      if (en) begin
        case (mode)
          1: q = d;
          2: begin so = q / (m / 2); q = (q * 2 + s) % m; end
          3: begin so = q % 2; q = q / 2 + s * (m / 2); end
          4: begin so = q / (m / 2); q = (q * 2 + so) % m; end
          5: begin so = q % 2; q = q / 2 + so * (m / 2); end
          6: begin wr = (q == m - 1); q = (q + 1) % m; end
          7: begin wr = (q == 0); q = (q + m - 1) % m; end
          default: ;
        endcase
      end
    end
  endtask

  int ma_q, ma_s, ma_w, mb_q, mb_s, mb_w;
  bit va = 0, vb = 0;

  always @(posedge clk) begin : model_a
    int tq, ts, tw;
    tq = ma_q; ts = ma_s; tw = ma_w;
    model_step(8, 'hA5, rst_a, bus_a.en, int'(bus_a.mode), int'(bus_a.d),
               int'(bus_a.ser_in), tq, ts, tw);
    ma_q <= tq; ma_s <= ts; ma_w <= tw;
    if (!rst_a) va <= 1'b1;
  end

  always @(posedge clk) begin : model_b
    int tq, ts, tw;
    tq = mb_q; ts = mb_s; tw = mb_w;
    model_step(1, 0, rst_b, bus_b.en, int'(bus_b.mode), int'(bus_b.d),
               int'(bus_b.ser_in), tq, ts, tw);
    mb_q <= tq; mb_s <= ts; mb_w <= tw;
    if (!rst_b) vb <= 1'b1;
  end

  always @(negedge clk) begin
    if (va) begin
      chk("a_q", int'(bus_a.q), ma_q);
      chk("a_notq", int'(bus_a.notq), (~ma_q) & 'hFF);
      chk("a_ser_out", int'(bus_a.ser_out), ma_s);
      chk("a_wrap", int'(bus_a.wrap), ma_w);
    end
    if (vb) begin
      chk("b_q", int'(bus_b.q), mb_q);
      chk("b_notq", int'(bus_b.notq), (~mb_q) & 1);
      chk("b_ser_out", int'(bus_b.ser_out), mb_s);
      chk("b_wrap", int'(bus_b.wrap), mb_w);
    end
  end

  task automatic rand_a();
    rst_a = ($urandom_range(31) != 0);
    bus_a.en = ($urandom_range(7) != 0);
    bus_a.mode = 3'($urandom_range(7));
    bus_a.d = 8'($urandom);
    bus_a.ser_in = 1'($urandom);
  endtask

  task automatic rand_b();
    rst_b = ($urandom_range(31) != 0);
    bus_b.en = ($urandom_range(7) != 0);
    bus_b.mode = 3'($urandom_range(7));
    bus_b.d = 1'($urandom);
    bus_b.ser_in = 1'($urandom);
  endtask

  task automatic a_op(input bit rst, input bit en, input logic [2:0] mode,
                      input logic [7:0] d, input bit s);
    @(negedge clk);
    rst_a = rst; bus_a.en = en; bus_a.mode = mode; bus_a.d = d; bus_a.ser_in = s;
    rand_b();
    @(posedge clk); #1;
  endtask

  task automatic b_op(input bit rst, input bit en, input logic [2:0] mode, input bit s);
    @(negedge clk);
    rst_b = rst; bus_b.en = en; bus_b.mode = mode; bus_b.d = 1'($urandom); bus_b.ser_in = s;
    rand_a();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    bus_a.en = 1'b0; bus_a.mode = 3'd0; bus_a.d = 8'd0; bus_a.ser_in = 1'b0;
    bus_b.en = 1'b0; bus_b.mode = 3'd0; bus_b.d = 1'b0; bus_b.ser_in = 1'b0;

    // reset overrides a pending load
    a_op(0, 1, 3'b001, 8'hFF, 0);
    chk("rst_q", int'(bus_a.q), 'hA5);
    chk("rst_notq", int'(bus_a.notq), 'h5A);
    chk("rst_ser", int'(bus_a.ser_out), 0);
    chk("rst_wrap", int'(bus_a.wrap), 0);

    a_op(1, 1, 3'b001, 8'h81, 0);
    a_op(1, 1, 3'b010, 8'h00, 0);
    chk("shl_q", int'(bus_a.q), 'h02);
    chk("shl_ser", int'(bus_a.ser_out), 1);
    a_op(1, 1, 3'b001, 8'h81, 0);
    a_op(1, 1, 3'b011, 8'h00, 1);
    chk("shr_q", int'(bus_a.q), 'hC0);
    chk("shr_ser", int'(bus_a.ser_out), 1);

    a_op(1, 1, 3'b001, 8'h81, 0);
    a_op(1, 1, 3'b100, 8'h00, 0);
    chk("rol_q", int'(bus_a.q), 'h03);
    chk("rol_ser", int'(bus_a.ser_out), 1);
    for (int i = 0; i < 8; i++) a_op(1, 1, 3'b100, 8'h00, 0);
    chk("rol8_q", int'(bus_a.q), 'h03);
    a_op(1, 1, 3'b001, 8'h81, 0);
    a_op(1, 1, 3'b101, 8'h00, 0);
    chk("ror_q", int'(bus_a.q), 'hC0);
    chk("ror_ser", int'(bus_a.ser_out), 1);

    a_op(1, 1, 3'b001, 8'hFE, 0);
    a_op(1, 1, 3'b110, 8'h00, 0);
    chk("up1_q", int'(bus_a.q), 'hFF); chk("up1_wrap", int'(bus_a.wrap), 0);
    a_op(1, 1, 3'b110, 8'h00, 0);
    chk("up2_q", int'(bus_a.q), 'h00); chk("up2_wrap", int'(bus_a.wrap), 1);
    a_op(1, 1, 3'b110, 8'h00, 0);
    chk("up3_q", int'(bus_a.q), 'h01); chk("up3_wrap", int'(bus_a.wrap), 0);

    a_op(1, 1, 3'b001, 8'h00, 0);
    a_op(1, 1, 3'b111, 8'h00, 0);
    chk("dn1_q", int'(bus_a.q), 'hFF); chk("dn1_wrap", int'(bus_a.wrap), 1);
    a_op(1, 1, 3'b111, 8'h00, 0);
    chk("dn2_q", int'(bus_a.q), 'hFE); chk("dn2_wrap", int'(bus_a.wrap), 0);

    // ser_out is still 1 from the rotate-right above
    a_op(1, 1, 3'b001, 8'h3C, 0);
    for (int i = 0; i < 3; i++) begin
      a_op(1, 0, 3'b110, 8'h00, 0);
      chk("hold_q", int'(bus_a.q), 'h3C);
      chk("hold_ser", int'(bus_a.ser_out), 1);
      chk("hold_wrap", int'(bus_a.wrap), 0);
    end
    a_op(1, 1, 3'b110, 8'h00, 0);
    chk("en_up_q", int'(bus_a.q), 'h3D);

    a_op(1, 1, 3'b001, 8'hFF, 0);
    a_op(0, 1, 3'b110, 8'h00, 0);
    chk("midrst_q", int'(bus_a.q), 'hA5);
    chk("midrst_wrap", int'(bus_a.wrap), 0);

    b_op(0, 1, 3'b110, 0);
    chk("b_rst_q", int'(bus_b.q), 0);
    b_op(1, 1, 3'b110, 0);
    chk("b_up1_q", int'(bus_b.q), 1); chk("b_up1_wrap", int'(bus_b.wrap), 0);
    b_op(1, 1, 3'b110, 0);
    chk("b_up2_q", int'(bus_b.q), 0); chk("b_up2_wrap", int'(bus_b.wrap), 1);
    b_op(1, 1, 3'b010, 1);
    chk("b_shl1_q", int'(bus_b.q), 1); chk("b_shl1_ser", int'(bus_b.ser_out), 0);
    b_op(1, 1, 3'b010, 0);
    chk("b_shl2_q", int'(bus_b.q), 0); chk("b_shl2_ser", int'(bus_b.ser_out), 1);

    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      rand_a();
      rand_b();
    end
    @(negedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
